// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and writer state encoding.
package fb_pkg;

  localparam int unsigned FB_WIDTH      = 240;
  localparam int unsigned FB_HEIGHT     = 320;
  localparam int unsigned FB_DEPTH      = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned FB_ADDR_WIDTH = 17;
  localparam int unsigned PIXEL_WIDTH   = 16;

  typedef enum logic [0:0] {
    STREAM = 1'b0,
    CLEAR  = 1'b1
  } fb_writer_state_t;

endpackage

// File: rtl/fb_coord_counter.sv
// Raster position counter: hcount/vcount plus an incrementally kept linear address.
module fb_coord_counter
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH      = FB_WIDTH,
  parameter int unsigned HEIGHT     = FB_HEIGHT,
  parameter int unsigned ADDR_WIDTH = FB_ADDR_WIDTH,
  localparam int unsigned HW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int unsigned VW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  advance_in,
  input  logic                  restart_in,
  output logic [HW-1:0]         hcount_out,
  output logic [VW-1:0]         vcount_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  wrap_out
);

  logic at_end;

  // Current position is the last pixel of the frame; the next advance wraps.
  assign at_end   = (hcount_out == HW'(WIDTH - 1)) && (vcount_out == VW'(HEIGHT - 1));
  assign wrap_out = at_end;

  // Restart alone parks at (0,0); restart with advance means position 0 was just
  // consumed, so the counter lands on (1,0).
  always_ff @(posedge clk_in) begin
    if (rst_in || (restart_in && !advance_in)) begin
      hcount_out <= '0;
      vcount_out <= '0;
      addr_out   <= '0;
    end else if (restart_in) begin
      hcount_out <= HW'(1);
      vcount_out <= '0;
      addr_out   <= ADDR_WIDTH'(1);
    end else if (advance_in) begin
      if (at_end) begin
        hcount_out <= '0;
        vcount_out <= '0;
        addr_out   <= '0;
      end else if (hcount_out == HW'(WIDTH - 1)) begin
        hcount_out <= '0;
        vcount_out <= vcount_out + 1'b1;
        addr_out   <= addr_out + 1'b1;
      end else begin
        hcount_out <= hcount_out + 1'b1;
        addr_out   <= addr_out + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer write-side address generator with streaming input and hardware clear.
module fb_writer #(
  parameter int unsigned FB_WIDTH    = fb_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT   = fb_pkg::FB_HEIGHT,
  parameter int unsigned PIXEL_WIDTH = fb_pkg::PIXEL_WIDTH,
  parameter int unsigned ADDR_WIDTH  = fb_pkg::FB_ADDR_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   pixel_valid_in,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   pixel_sof_in,
  output logic                   pixel_ready_out,
  input  logic                   clear_in,
  input  logic [PIXEL_WIDTH-1:0] clear_color_in,
  output logic                   we_out,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  output logic [PIXEL_WIDTH-1:0] data_out,
  output logic                   busy_out,
  output logic                   frame_done_out
);

  import fb_pkg::*;

  localparam int unsigned HW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
  localparam int unsigned VW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;

  fb_writer_state_t       state;
  logic [PIXEL_WIDTH-1:0] clear_color;
  logic                   in_clear;
  logic                   handshake;
  logic                   clear_go;
  logic                   cnt_advance;
  logic                   cnt_restart;
  logic                   cnt_wrap;
  logic [HW-1:0]          cnt_h;
  logic [VW-1:0]          cnt_v;
  logic [ADDR_WIDTH-1:0]  cnt_addr;

  assign in_clear        = (state == CLEAR);
  assign busy_out        = in_clear;
  assign pixel_ready_out = !rst_in && !in_clear;
  assign handshake       = pixel_valid_in && pixel_ready_out;
  assign clear_go        = clear_in && !in_clear;

  // Counter control: a clear request parks at (0,0) even if a pixel lands in the
  // same cycle; that pixel is still written at the old position.
  always_comb begin
    cnt_advance = 1'b0;
    cnt_restart = 1'b0;
    if (in_clear) begin
      cnt_advance = 1'b1;
    end else begin
      cnt_advance = handshake && !clear_go;
      cnt_restart = clear_go || (handshake && pixel_sof_in);
    end
  end

  fb_coord_counter #(
    .WIDTH      (FB_WIDTH),
    .HEIGHT     (FB_HEIGHT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_coord (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .advance_in (cnt_advance),
    .restart_in (cnt_restart),
    .hcount_out (cnt_h),
    .vcount_out (cnt_v),
    .addr_out   (cnt_addr),
    .wrap_out   (cnt_wrap)
  );

  // The incremental address must always equal vcount*width + hcount.
  always_comb begin
    assert (int'(cnt_addr) == int'(cnt_v) * int'(FB_WIDTH) + int'(cnt_h));
  end

  // Mode sequencing: enter CLEAR on request, leave after the last address is issued.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= STREAM;
    end else if (clear_go) begin
      state <= CLEAR;
    end else if (in_clear && cnt_wrap) begin
      state <= STREAM;
    end
  end

  // Fill colour is captured once, when the clear is accepted.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clear_color <= '0;
    end else if (clear_go) begin
      clear_color <= clear_color_in;
    end
  end

  // Registered BRAM write port; address and data hold when nothing is written.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      we_out         <= 1'b0;
      addr_out       <= '0;
      data_out       <= '0;
      frame_done_out <= 1'b0;
    end else begin
      we_out         <= in_clear || handshake;
      frame_done_out <= handshake && !pixel_sof_in && cnt_wrap;
      if (in_clear) begin
        addr_out <= cnt_addr;
        data_out <= clear_color;
      end else if (handshake) begin
        addr_out <= pixel_sof_in ? '0 : cnt_addr;
        data_out <= pixel_in;
      end
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer; frame height reduced to keep full-frame runs short.
module tb_fb_writer;

  localparam int W     = 240;
  localparam int H     = 64;
  localparam int DEPTH = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] pix;
  logic        sof;
  logic        ready;
  logic        clr;
  logic [15:0] color;
  logic        we;
  logic [16:0] addr;
  logic [15:0] data;
  logic        busy;
  logic        fd;

  int errors = 0;
  int checks = 0;

  fb_writer #(
    .FB_WIDTH    (W),
    .FB_HEIGHT   (H),
    .PIXEL_WIDTH (16),
    .ADDR_WIDTH  (17)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .pixel_valid_in  (valid),
    .pixel_in        (pix),
    .pixel_sof_in    (sof),
    .pixel_ready_out (ready),
    .clear_in        (clr),
    .clear_color_in  (color),
    .we_out          (we),
    .addr_out        (addr),
    .data_out        (data),
    .busy_out        (busy),
    .frame_done_out  (fd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; valid = 1'b0; sof = 1'b0; clr = 1'b0; pix = '0; color = '0;
    step; step;
    rst = 1'b0;
  endtask

  // Offer one pixel for one cycle and check the write it produces.
  task automatic send_chk(input string tag, input logic [15:0] p, input logic s, input int exp_addr);
    valid = 1'b1; pix = p; sof = s;
    step;
    valid = 1'b0; sof = 1'b0;
    check({tag, "_we"},   32'(we),   32'd1);
    check({tag, "_addr"}, 32'(addr), 32'(exp_addr));
    check({tag, "_data"}, 32'(data), 32'(p));
  endtask

  task automatic send_quiet(input logic [15:0] p);
    valid = 1'b1; pix = p; sof = 1'b0;
    step;
    valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int busy_bad;
    int fd_cnt;
    int fd_addr;

    // Reset values
    rst = 1'b1; valid = 1'b0; sof = 1'b0; clr = 1'b0; pix = '0; color = '0;
    step; step;
    check("rst_we",    32'(we),    32'd0);
    check("rst_addr",  32'(addr),  32'd0);
    check("rst_data",  32'(data),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_fd",    32'(fd),    32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(ready), 32'd1);

    // Three back-to-back pixels, then an idle cycle
    send_chk("p0", 16'h1111, 1'b0, 0);
    send_chk("p1", 16'h2222, 1'b0, 1);
    send_chk("p2", 16'h3333, 1'b0, 2);
    step;
    check("idle_we",   32'(we),   32'd0);
    check("idle_addr", 32'(addr), 32'd2);
    check("idle_data", 32'(data), 32'h3333);

    // 241 pixels with random gaps: crosses the first row boundary
    do_reset;
    for (int i = 0; i < 241; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        step;
        check("gap_we", 32'(we), 32'd0);
      end
      send_chk("row", 16'(i * 3 + 7), 1'b0, i);
    end

    // Full frame plus one pixel
    do_reset;
    bad = 0; fd_cnt = 0; fd_addr = -1;
    for (int i = 0; i <= DEPTH; i++) begin
      valid = 1'b1; pix = 16'(i) ^ 16'hA5A5;
      step;
      if (!(we && (int'(addr) == (i % DEPTH)) && (data == pix))) bad++;
      if (fd) begin
        fd_cnt++;
        fd_addr = int'(addr);
      end
    end
    valid = 1'b0;
    check("frame_write_errs", 32'(bad),    32'd0);
    check("frame_done_count", 32'(fd_cnt), 32'd1);
    check("frame_done_addr",  32'(fd_addr), 32'(DEPTH - 1));
    check("frame_wrap_addr",  32'(addr),   32'd0);
    check("frame_wrap_fd",    32'(fd),     32'd0);

    // SOF restarts the raster
    do_reset;
    for (int i = 0; i < 100; i++) send_quiet(16'(i));
    send_chk("sof", 16'hC0DE, 1'b1, 0);
    check("sof_fd", 32'(fd), 32'd0);
    send_chk("after_sof", 16'hC0DF, 1'b0, 1);

    // Clear while streaming at addr 500, with a pixel in the same cycle
    do_reset;
    for (int i = 0; i < 500; i++) send_quiet(16'(i));
    valid = 1'b1; pix = 16'h5A5A; clr = 1'b1; color = 16'hF800;
    step;
    clr = 1'b0; color = 16'h001F;
    check("clr_pix_we",   32'(we),    32'd1);
    check("clr_pix_addr", 32'(addr),  32'd500);
    check("clr_pix_data", 32'(data),  32'h5A5A);
    check("clr_busy",     32'(busy),  32'd1);
    check("clr_ready",    32'(ready), 32'd0);
    bad = 0; busy_bad = 0; fd_cnt = 0;
    pix = 16'h0BAD;
    for (int k = 0; k < DEPTH; k++) begin
      clr = (k == 10);
      step;
      if (!(we && (int'(addr) == k) && (data == 16'hF800))) bad++;
      if (fd) fd_cnt++;
      if (k < DEPTH - 1) begin
        if (!busy || ready) busy_bad++;
      end else begin
        if (busy || !ready) busy_bad++;
      end
    end
    valid = 1'b0; clr = 1'b0;
    check("clear_write_errs", 32'(bad),      32'd0);
    check("clear_busy_errs",  32'(busy_bad), 32'd0);
    check("clear_fd_count",   32'(fd_cnt),   32'd0);
    step;
    check("clear_no_extra_we", 32'(we), 32'd0);
    send_chk("post_clear", 16'hBEEF, 1'b0, 0);

    // Reset 1000 cycles into a clear
    do_reset;
    clr = 1'b1; color = 16'h07E0;
    step;
    clr = 1'b0;
    repeat (1000) step;
    check("midclr_busy", 32'(busy), 32'd1);
    check("midclr_we",   32'(we),   32'd1);
    rst = 1'b1;
    step;
    check("abort_we",    32'(we),    32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_fd",    32'(fd),    32'd0);
    check("abort_addr",  32'(addr),  32'd0);
    check("abort_data",  32'(data),  32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready_release", 32'(ready), 32'd1);
    send_chk("post_abort", 16'h1234, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
# fb_writer

Write-side counterpart of the display-side coordinate scaler. It accepts a raster-ordered pixel stream from the GPU pipeline over a valid/ready handshake and generates framebuffer BRAM write addresses for the 240×320 buffer the display path reads. It also provides a hardware clear that fills the whole buffer with one colour. It sits between the rasterizer output and the framebuffer BRAM write port (port A); the display scaler drives the read port.

## Interface
Parameters:
- FB_WIDTH, 240, pixels per row (hcount range 0..239)
- FB_HEIGHT, 320, rows per frame (vcount range 0..319)
- PIXEL_WIDTH, 16, bits per pixel (RGB565)
- ADDR_WIDTH, 17, BRAM address width; must satisfy 2^ADDR_WIDTH ≥ FB_WIDTH·FB_HEIGHT

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- pixel_valid_in  input  1  pixel_in is valid
- pixel_in  input  PIXEL_WIDTH  pixel data, raster order
- pixel_sof_in  input  1  qualifies pixel_in as the first pixel of a frame (position (0,0))
- pixel_ready_out  output  1  block accepts a pixel this cycle
- clear_in  input  1  single-cycle request to fill the buffer with clear_color_in
- clear_color_in  input  PIXEL_WIDTH  fill colour, sampled in the cycle clear_in is accepted
- we_out  output  1  BRAM write enable
- addr_out  output  ADDR_WIDTH  BRAM write address = vcount·FB_WIDTH + hcount
- data_out  output  PIXEL_WIDTH  BRAM write data
- busy_out  output  1  clear in progress
- frame_done_out  output  1  one-cycle pulse, coincident with the write of pixel (239,319)

## Operation
- FSM states: STREAM and CLEAR. Reset state is STREAM, with position (hcount, vcount, addr) = (0, 0, 0).
- STREAM:
  - pixel_ready_out = 1.
  - A handshake is pixel_valid_in && pixel_ready_out.
  - On a handshake, pixel_in is written at the current position and the position advances.
  - If pixel_sof_in is set with the handshake, the pixel is written at addr 0 and the position becomes (1,0), regardless of the prior position.
- Position advance:
  - hcount increments.
  - At FB_WIDTH−1, hcount wraps to 0 and vcount increments.
  - At (FB_WIDTH−1, FB_HEIGHT−1), the position wraps to (0,0) and frame_done_out pulses with that write.
  - addr is maintained incrementally: +1 per advance, reset to 0 on frame wrap or SOF. There is no multiplier.
- clear_in in STREAM:
  - Latches clear_color_in, resets the position to (0,0) and enters CLEAR the next cycle.
  - If a handshake occurs in the same cycle, that pixel is still written. The clear then overwrites it.
- CLEAR:
  - pixel_ready_out = 0 and busy_out = 1.
  - Writes the latched colour to addresses 0..FB_WIDTH·FB_HEIGHT−1, one per cycle, with no gaps.
  - After writing the last address, returns to STREAM with position (0,0).
  - frame_done_out does not pulse during a clear.
  - clear_in is ignored while in CLEAR.
- pixel_valid_in gaps produce no write. Position and outputs hold, except we_out = 0.

## Timing
- Reset values: we_out = 0, addr_out = 0, data_out = 0, busy_out = 0, frame_done_out = 0. pixel_ready_out = 0 while rst_in is high and 1 the cycle after rst_in deasserts.
- Write latency: we_out, addr_out and data_out are registered and appear one cycle after the handshake. Sustained throughput is one pixel per cycle.
- Clear timing:
  - First clear write appears 2 cycles after clear_in (one cycle to enter CLEAR, one cycle of output register).
  - 76800 consecutive we_out cycles follow.
  - busy_out is high from the cycle after clear_in until the cycle after the final clear write is issued.
  - pixel_ready_out returns high the cycle after the state returns to STREAM.
- frame_done_out is registered alongside we_out, so it is high in the same cycle as addr_out = 76799.
- rst_in mid-clear aborts the clear. The next cycle shows we_out = 0, busy_out = 0 and position (0,0).

## Structure
- Shared package fb_pkg holds:
  - FB_WIDTH, FB_HEIGHT, FB_DEPTH (= product), FB_ADDR_WIDTH, PIXEL_WIDTH.
  - The typedef enum fb_writer_state_t {STREAM, CLEAR}.
  - The display scaler uses the same width and height constants for its valid-address bounds.
- Sub-module fb_coord_counter is used for both streaming and clearing:
  - Function: hcount/vcount/addr with advance, restart-to-zero and wrap flag.
  - Ports: clk_in, rst_in, advance_in, restart_in, hcount_out, vcount_out, addr_out, wrap_out.
  - The restart-with-advance case produces the (1,0) SOF behaviour.

## Test plan
- Reset, then pixels 0x1111, 0x2222, 0x3333 on consecutive cycles → we_out is high for 3 cycles starting one cycle later, with addr 0,1,2 and data matching.
- 241 pixels with random valid gaps → the 241st is written at addr 240; no write occurs in gap cycles.
- 76801 pixels → frame_done_out is a single pulse with addr_out = 76799; pixel 76801 is written at addr 0.
- 100 pixels, then a pixel with pixel_sof_in = 1 → written at addr 0; the next pixel goes to addr 1.
- clear_in with color 0xF800 while streaming at addr 500:
  - busy_out and pixel_ready_out behave as specified.
  - Exactly 76800 writes occur at sequential addrs 0..76799 with data 0xF800.
  - The next streamed pixel is written at addr 0.
- rst_in asserted 1000 cycles into a clear → all outputs take reset values; pixel_ready_out = 1 after release; the next pixel is written at addr 0.
